// File: rtl/reorder_buffer_multi.sv
// reorder_buffer_multi
// Reorder buffer for the Tomasulo back end. It allocates one entry per issued
// instruction in program order and captures results from NCDB common-data-bus
// channels. It retires up to two completed entries per cycle in order, handles
// precise exceptions and an external flush, and reports occupancy.
//
// Ports:
//   CLK, Reset_n        clock (rising edge), asynchronous active-low reset
//   Append, AppendDest, AppendWB
//                       allocate an entry at the tail (ignored while Full)
//   Full, Empty, Tail, Count
//                       occupancy, combinational from the pointers
//   CDB                 NCDB channels of {Value, Exc, Tag, Valid}, Valid at the LSB
//   Flush               discard every entry (branch mispredict)
//   WA, WE, WD          registered commit port; slot 1 is in the upper half
//   Exception, ExcTag   one-cycle exception pulse, and the tag held until the next one
module reorder_buffer_multi #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned NCDB   = 4,
  localparam int unsigned TAG_W = $clog2(DEPTH),
  localparam int unsigned CDB_W = DATA_W + TAG_W + 2
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  Append,
  input  logic [REG_W-1:0]      AppendDest,
  input  logic                  AppendWB,
  output logic                  Full,
  output logic                  Empty,
  output logic [TAG_W-1:0]      Tail,
  output logic [TAG_W:0]        Count,
  input  logic [NCDB*CDB_W-1:0] CDB,
  input  logic                  Flush,
  output logic [2*REG_W-1:0]    WA,
  output logic [1:0]            WE,
  output logic [2*DATA_W-1:0]   WD,
  output logic                  Exception,
  output logic [TAG_W-1:0]      ExcTag
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] TwoCount  = (TAG_W+1)'(2);

  // Pointers carry one extra wrap bit, so Full and Empty stay distinct.
  logic [TAG_W:0]      head_q, head_d, tail_q, tail_d, count, n_commit;
  logic [DEPTH-1:0]    busy_q, busy_d, ready_q, ready_d, exc_q, exc_d, wb_q, wb_d;
  logic [REG_W-1:0]    dest_q  [DEPTH];
  logic [REG_W-1:0]    dest_d  [DEPTH];
  logic [DATA_W-1:0]   value_q [DEPTH];
  logic [DATA_W-1:0]   value_d [DEPTH];

  logic [2*REG_W-1:0]  wa_q, wa_d;
  logic [1:0]          we_q, we_d;
  logic [2*DATA_W-1:0] wd_q, wd_d;
  logic                exception_q, exception_d;
  logic [TAG_W-1:0]    exc_tag_q, exc_tag_d;

  logic [TAG_W-1:0]    h0, h1, t_idx;
  logic                c0, exc0, norm0, c1, append_ok;
  logic [CDB_W-1:0]    cdb_ch;

  assign count  = tail_q - head_q;
  assign Count  = count;
  assign Full   = (count == FullCount);
  assign Empty  = (count == '0);
  assign Tail   = tail_q[TAG_W-1:0];
  assign t_idx  = tail_q[TAG_W-1:0];

  // Commit eligibility is evaluated on pre-edge state only.
  assign h0     = head_q[TAG_W-1:0];
  assign h1     = h0 + TAG_W'(1);
  assign c0     = busy_q[h0] & ready_q[h0];
  assign exc0   = c0 & exc_q[h0];
  assign norm0  = c0 & ~exc_q[h0];
  assign c1     = norm0 & (count >= TwoCount) & busy_q[h1] & ready_q[h1] & ~exc_q[h1];
  assign append_ok = Append & ~Full;
  assign n_commit  = c1 ? TwoCount : (norm0 ? (TAG_W+1)'(1) : '0);

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    exc_d   = exc_q;
    wb_d    = wb_q;
    dest_d  = dest_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cdb_ch  = '0;

    // Ascending scan: a later (higher) channel overwrites an earlier hit on the same tag.
    for (int k = 0; k < NCDB; k++) begin
      cdb_ch = CDB[k*CDB_W +: CDB_W];
      if (cdb_ch[0] && busy_q[cdb_ch[TAG_W:1]]) begin
        ready_d[cdb_ch[TAG_W:1]] = 1'b1;
        exc_d[cdb_ch[TAG_W:1]]   = cdb_ch[TAG_W+1];
        value_d[cdb_ch[TAG_W:1]] = cdb_ch[CDB_W-1 -: DATA_W];
      end
    end

    if (norm0) busy_d[h0] = 1'b0;
    if (c1)    busy_d[h1] = 1'b0;
    head_d = head_q + n_commit;

    // The tail slot is never busy when not Full, so the pre-edge busy check above
    // already keeps a same-cycle CDB hit off the new entry.
    if (append_ok) begin
      busy_d[t_idx]  = 1'b1;
      ready_d[t_idx] = 1'b0;
      exc_d[t_idx]   = 1'b0;
      wb_d[t_idx]    = AppendWB;
      dest_d[t_idx]  = AppendDest;
      tail_d         = tail_q + (TAG_W+1)'(1);
    end

    if (exc0 || Flush) begin
      busy_d  = '0;
      ready_d = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_comb begin
    wa_d        = '0;
    we_d        = '0;
    wd_d        = '0;
    exception_d = 1'b0;
    exc_tag_d   = exc_tag_q;
    if (!Flush) begin
      if (exc0) begin
        exception_d = 1'b1;
        exc_tag_d   = h0;
      end else if (norm0) begin
        wa_d[REG_W-1:0]  = dest_q[h0];
        wd_d[DATA_W-1:0] = value_q[h0];
        we_d[0]          = wb_q[h0];
        if (c1) begin
          wa_d[2*REG_W-1:REG_W]   = dest_q[h1];
          wd_d[2*DATA_W-1:DATA_W] = value_q[h1];
          we_d[1]                 = wb_q[h1];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      exc_q       <= '0;
      wb_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
      wa_q        <= '0;
      we_q        <= '0;
      wd_q        <= '0;
      exception_q <= 1'b0;
      exc_tag_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      exc_q       <= exc_d;
      wb_q        <= wb_d;
      dest_q      <= dest_d;
      value_q     <= value_d;
      wa_q        <= wa_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      exception_q <= exception_d;
      exc_tag_q   <= exc_tag_d;
    end
  end

  assign WA        = wa_q;
  assign WE        = we_q;
  assign WD        = wd_q;
  assign Exception = exception_q;
  assign ExcTag    = exc_tag_q;

endmodule

// File: tb/tb_reorder_buffer_multi.sv
// Directed bench for reorder_buffer_multi (DEPTH=8, NCDB=4). Inputs change 1 time unit
// after a rising edge, and outputs are checked at that same point.
module tb_reorder_buffer_multi;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NCDB   = 4;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned CDB_W  = DATA_W + TAG_W + 2;

  logic                  CLK = 1'b0;
  logic                  Reset_n = 1'b0;
  logic                  Append = 1'b0;
  logic [REG_W-1:0]      AppendDest = '0;
  logic                  AppendWB = 1'b0;
  logic                  Full, Empty;
  logic [TAG_W-1:0]      Tail;
  logic [TAG_W:0]        Count;
  logic [NCDB*CDB_W-1:0] CDB = '0;
  logic                  Flush = 1'b0;
  logic [2*REG_W-1:0]    WA;
  logic [1:0]            WE;
  logic [2*DATA_W-1:0]   WD;
  logic                  Exception;
  logic [TAG_W-1:0]      ExcTag;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer_multi #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .NCDB  (NCDB)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .Append    (Append),
    .AppendDest(AppendDest),
    .AppendWB  (AppendWB),
    .Full      (Full),
    .Empty     (Empty),
    .Tail      (Tail),
    .Count     (Count),
    .CDB       (CDB),
    .Flush     (Flush),
    .WA        (WA),
    .WE        (WE),
    .WD        (WD),
    .Exception (Exception),
    .ExcTag    (ExcTag)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cdb(input int k, input int tag, input logic [31:0] val, input logic exc);
    logic [2:0] t;
    t = 3'(tag);
    CDB[k*CDB_W +: CDB_W] = {val, exc, t, 1'b1};
  endtask

  task automatic app(input int dest, input logic wb);
    Append     = 1'b1;
    AppendDest = 4'(dest);
    AppendWB   = wb;
    tick();
    Append     = 1'b0;
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_full", Full, 0);
    check("rst_empty", Empty, 1);
    check("rst_count", Count, 0);
    check("rst_tail", Tail, 0);
    check("rst_commit", {WE, WA, Exception, ExcTag}, 0);
    check("rst_wd", WD, 0);
    #5 Reset_n = 1'b1;
    #3;

    // Fill: 8 appends, then a 9th is ignored
    for (int i = 1; i <= 8; i++) app(i, 1'b1);
    check("fill_count", Count, 8);
    check("fill_full", Full, 1);
    check("fill_tail", Tail, 0);
    app(9, 1'b1);
    check("fill_over_count", Count, 8);
    check("fill_over_tail", Tail, 0);
    do_flush();
    check("flush_count", Count, 0);

    // In-order retire: complete tags 2, 1, 0
    app(3, 1'b1);
    app(4, 1'b1);
    app(5, 1'b1);
    set_cdb(0, 2, 32'hA2, 1'b0);
    tick();
    check("ord_we_t2", WE, 0);
    set_cdb(0, 1, 32'hA1, 1'b0);
    tick();
    check("ord_we_t1", WE, 0);
    set_cdb(0, 0, 32'hA0, 1'b0);
    tick();
    check("ord_we_capture_edge", WE, 0);
    CDB = '0;
    tick();
    check("ord_we_pair", WE, 2'b11);
    check("ord_wa_pair", WA, 8'h43);
    check("ord_wd_pair", WD, {32'hA1, 32'hA0});
    tick();
    check("ord_we_t2c", WE, 2'b01);
    check("ord_wa_t2c", WA, 8'h05);
    check("ord_wd_t2c", WD, 64'hA2);
    check("ord_empty", Empty, 1);

    // CDB collision: channels 0 and 3 both hit tag 1
    do_flush();
    app(6, 1'b1);
    app(7, 1'b1);
    set_cdb(1, 0, 32'h50, 1'b0);
    set_cdb(0, 1, 32'h11, 1'b0);
    set_cdb(3, 1, 32'h33, 1'b0);
    tick();
    CDB = '0;
    tick();
    check("col_we", WE, 2'b11);
    check("col_wd", WD, {32'h33, 32'h50});

    // Exception on tag 1 with entries 0..3 all ready
    do_flush();
    for (int i = 1; i <= 4; i++) app(i, 1'b1);
    for (int k = 0; k < 4; k++) set_cdb(k, k, 32'hB0 + 32'(k), (k == 1));
    tick();
    CDB = '0;
    tick();
    check("exc_a_we", WE, 2'b01);
    check("exc_a_wa", WA, 8'h01);
    check("exc_a_wd", WD, 64'hB0);
    check("exc_a_pulse", Exception, 0);
    tick();
    check("exc_b_pulse", Exception, 1);
    check("exc_b_tag", ExcTag, 1);
    check("exc_b_we", WE, 0);
    check("exc_b_empty", Empty, 1);
    check("exc_b_tail", Tail, 0);
    tick();
    check("exc_after_pulse", Exception, 0);
    check("exc_after_tag", ExcTag, 1);
    check("exc_after_empty", Empty, 1);

    // Flush together with Append, CDB hit and an eligible commit
    app(9, 1'b1);
    app(10, 1'b1);
    set_cdb(0, 0, 32'hC0, 1'b0);
    tick();
    CDB = '0;
    check("fc_count_pre", Count, 2);
    Flush  = 1'b1;
    Append = 1'b1;
    AppendDest = 4'd11;
    AppendWB   = 1'b1;
    set_cdb(0, 1, 32'hC1, 1'b0);
    tick();
    Flush = 1'b0;
    Append = 1'b0;
    CDB = '0;
    check("fc_we", WE, 0);
    check("fc_count", Count, 0);
    check("fc_tail", Tail, 0);
    check("fc_exc", Exception, 0);
    tick();
    check("fc_we_next", WE, 0);
    check("fc_empty_next", Empty, 1);

    // Wrap stress: steady state at Count=7, one append and one commit per cycle
    for (int s = 0; s < 7; s++) app(s & 15, 1'b1);
    set_cdb(0, 0, 32'h1000, 1'b0);
    tick();
    check("wrap_pre_count", Count, 7);
    check("wrap_pre_we", WE, 0);
    for (int i = 0; i < 40; i++) begin
      Append     = 1'b1;
      AppendDest = 4'((7 + i) & 15);
      AppendWB   = 1'b1;
      set_cdb(0, (i + 1) % 8, 32'h1000 + 32'(i + 1), 1'b0);
      tick();
      check($sformatf("wrap_occ_%0d", i), {Full, Empty, Count}, {1'b0, 1'b0, 4'd7});
      check($sformatf("wrap_we_%0d", i), WE, 2'b01);
      check($sformatf("wrap_wa_%0d", i), WA, 64'(i & 15));
      check($sformatf("wrap_wd_%0d", i), WD, 64'(32'h1000 + 32'(i)));
    end
    // Asynchronous reset mid-stream, inputs still active
    #2 Reset_n = 1'b0;
    #1;
    check("ar_count", Count, 0);
    check("ar_flags", {Full, Empty}, 2'b01);
    check("ar_tail", Tail, 0);
    check("ar_commit", {WE, WA, Exception, ExcTag}, 0);
    check("ar_wd", WD, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
